superh16_itlb_ptw: RTL and testbench

Hardware page-table walker answering the instruction TLB's miss interface. On a held `ptw_req` it walks the Sv39 three-level page table through a single-outstanding memory read port, then returns one `ptw_ack` pulse carrying the page-aligned physical base, page size, validity and execute permission. It sits between `superh16_itlb` and the L2/memory request arbiter.

---
 rtl/superh16_pkg.sv | 52 +++++
 rtl/superh16_ptw_pte_check.sv | 48 ++++
 rtl/superh16_itlb_ptw.sv | 147 ++++++++++++++
 tb/tb_superh16_itlb_ptw.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/superh16_pkg.sv
// ============================================================
// superh16_pkg -- shared Sv39 types and helpers for the ITLB walker
// Rev 1.0
// ============================================================
`default_nettype none

package superh16_pkg;

  localparam int VADDR_WIDTH   = 64;
  localparam int PADDR_WIDTH   = 56;
  localparam int PPN_WIDTH     = 44;
  localparam int SV39_VPN_BITS = 9;
  localparam int PTE_SIZE_LOG2 = 3;
  localparam int VPN_WIDTH     = 3 * SV39_VPN_BITS;

  localparam logic [1:0] PAGE_4K = 2'b00;
  localparam logic [1:0] PAGE_2M = 2'b01;
  localparam logic [1:0] PAGE_1G = 2'b10;

  typedef struct packed {
    logic [9:0]           reserved;
    logic [PPN_WIDTH-1:0] ppn;
    logic [1:0]           rsw;
    logic                 d;
    logic                 a;
    logic                 g;
    logic                 u;
    logic                 x;
    logic                 w;
    logic                 r;
    logic                 v;
  } sv39_pte_t;

  // Physical address of the PTE indexed by VPN[level] inside table 'base'.
  function automatic logic [PADDR_WIDTH-1:0] pte_addr(
    input logic [PPN_WIDTH-1:0] base,
    input logic [VPN_WIDTH-1:0] vpn,
    input logic [1:0]           level
  );
    logic [SV39_VPN_BITS-1:0] idx;
    case (level)
      2'd2:    idx = vpn[26:18];
      2'd1:    idx = vpn[17:9];
      default: idx = vpn[8:0];
    endcase
    return {base, 12'b0}
         + {{(PADDR_WIDTH-SV39_VPN_BITS-PTE_SIZE_LOG2){1'b0}}, idx, {PTE_SIZE_LOG2{1'b0}}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/superh16_ptw_pte_check.sv
// ============================================================
// superh16_ptw_pte_check -- combinational Sv39 PTE decode at a given level
// Rev 1.0
// ============================================================
`default_nettype none

module superh16_ptw_pte_check
  import superh16_pkg::*;
(
  input  sv39_pte_t              pte,
  input  logic [1:0]             level,
  output logic                   is_leaf,
  output logic                   fault,
  output logic [1:0]             page_size,
  output logic [PADDR_WIDTH-1:0] paddr
);

  logic w_misaligned;
  logic w_unused_pte;

  assign w_unused_pte = ^{pte.reserved, pte.rsw, pte.d, pte.a, pte.g, pte.u};

  always_comb begin
    is_leaf      = pte.r | pte.x;
    page_size    = PAGE_4K;
    w_misaligned = 1'b0;
    paddr        = {pte.ppn, 12'b0};
    case (level)
      2'd2: begin
        page_size    = PAGE_1G;
        w_misaligned = |pte.ppn[17:0];
        paddr[29:0]  = '0;
      end
      2'd1: begin
        page_size    = PAGE_2M;
        w_misaligned = |pte.ppn[8:0];
        paddr[20:0]  = '0;
      end
      default: ;
    endcase
    // A pointer at the last level has nowhere left to go.
    fault = !pte.v || (!pte.r && pte.w) || (is_leaf && w_misaligned)
          || (!is_leaf && (level == 2'd0));
  end

endmodule

`default_nettype wire

// File: rtl/superh16_itlb_ptw.sv
// ============================================================
// superh16_itlb_ptw -- Sv39 hardware page-table walker for ITLB misses
// Rev 1.0
// ============================================================
`default_nettype none

module superh16_itlb_ptw
  import superh16_pkg::*;
#(
  parameter int LEVELS    = 3,
  parameter int PTE_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ptw_req,
  input  logic [VADDR_WIDTH-1:0] ptw_vaddr,
  output logic                   ptw_ack,
  output logic [PADDR_WIDTH-1:0] ptw_paddr,
  output logic [1:0]             ptw_page_size,
  output logic                   ptw_valid,
  output logic                   ptw_executable,
  input  logic [PPN_WIDTH-1:0]   satp_ppn,
  input  logic                   flush,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic [PADDR_WIDTH-1:0] mem_req_addr,
  input  logic                   mem_resp_valid,
  input  logic [PTE_WIDTH-1:0]   mem_resp_data
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_HOLD  = 3'd4,
    ST_DRAIN = 3'd5
  } state_t;

  localparam logic [1:0] C_TOP_LEVEL = 2'(LEVELS - 1);

  state_t                 r_state;
  logic [1:0]             r_level;
  logic [VPN_WIDTH-1:0]   r_vpn;

  sv39_pte_t              w_pte;
  logic                   w_canonical;
  logic                   w_abort;
  logic                   w_is_leaf;
  logic                   w_fault;
  logic [1:0]             w_page_size;
  logic [PADDR_WIDTH-1:0] w_leaf_paddr;
  logic                   w_unused_vaddr;

  assign w_pte          = sv39_pte_t'(mem_resp_data);
  assign w_canonical    = (&ptw_vaddr[VADDR_WIDTH-1:38]) | ~(|ptw_vaddr[VADDR_WIDTH-1:38]);
  assign w_abort        = flush | ~ptw_req;
  assign w_unused_vaddr = ^ptw_vaddr[11:0];

  superh16_ptw_pte_check u_pte_check (
    .pte       (w_pte),
    .level     (r_level),
    .is_leaf   (w_is_leaf),
    .fault     (w_fault),
    .page_size (w_page_size),
    .paddr     (w_leaf_paddr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_level        <= '0;
      r_vpn          <= '0;
      ptw_ack        <= 1'b0;
      ptw_paddr      <= '0;
      ptw_page_size  <= PAGE_4K;
      ptw_valid      <= 1'b0;
      ptw_executable <= 1'b0;
      mem_req_valid  <= 1'b0;
      mem_req_addr   <= '0;
    end else begin
      ptw_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (ptw_req && !flush) begin
            r_vpn   <= ptw_vaddr[38:12];
            r_level <= C_TOP_LEVEL;
            if (!w_canonical) begin
              ptw_ack        <= 1'b1;
              ptw_valid      <= 1'b0;
              ptw_paddr      <= '0;
              ptw_page_size  <= PAGE_4K;
              ptw_executable <= 1'b0;
              r_state        <= ST_DONE;
            end else begin
              mem_req_valid <= 1'b1;
              mem_req_addr  <= pte_addr(satp_ppn, ptw_vaddr[38:12], C_TOP_LEVEL);
              r_state       <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (w_abort || mem_req_ready) mem_req_valid <= 1'b0;
          // An accepted request owes us a response even when aborting.
          if (w_abort)            r_state <= mem_req_ready ? ST_DRAIN : ST_IDLE;
          else if (mem_req_ready) r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (w_abort) begin
            r_state <= mem_resp_valid ? ST_IDLE : ST_DRAIN;
          end else if (mem_resp_valid) begin
            if (w_fault) begin
              ptw_ack        <= 1'b1;
              ptw_valid      <= 1'b0;
              ptw_paddr      <= '0;
              ptw_page_size  <= PAGE_4K;
              ptw_executable <= 1'b0;
              r_state        <= ST_DONE;
            end else if (w_is_leaf) begin
              ptw_ack        <= 1'b1;
              ptw_valid      <= 1'b1;
              ptw_paddr      <= w_leaf_paddr;
              ptw_page_size  <= w_page_size;
              ptw_executable <= w_pte.x;
              r_state        <= ST_DONE;
            end else begin
              r_level       <= r_level - 2'd1;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= pte_addr(w_pte.ppn, r_vpn, r_level - 2'd1);
              r_state       <= ST_REQ;
            end
          end
        end
        ST_DONE:  r_state <= ptw_valid ? ST_IDLE : ST_HOLD;
        ST_HOLD:  if (!ptw_req || flush) r_state <= ST_IDLE;
        ST_DRAIN: if (mem_resp_valid) r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  a_resp_protocol: assert property (@(posedge clk) disable iff (!rst_n)
    !(mem_resp_valid && (r_state == ST_IDLE || r_state == ST_REQ || r_state == ST_HOLD)));

endmodule

`default_nettype wire

// File: tb/tb_superh16_itlb_ptw.sv
// ============================================================
// tb_superh16_itlb_ptw -- scoreboard bench for the Sv39 ITLB walker
// Rev 1.0
// ============================================================
`default_nettype none

module tb_superh16_itlb_ptw;
  import superh16_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   ptw_req = 1'b0;
  logic [VADDR_WIDTH-1:0] ptw_vaddr = '0;
  logic                   ptw_ack;
  logic [PADDR_WIDTH-1:0] ptw_paddr;
  logic [1:0]             ptw_page_size;
  logic                   ptw_valid;
  logic                   ptw_executable;
  logic [PPN_WIDTH-1:0]   satp_ppn = 44'h100;
  logic                   flush = 1'b0;
  logic                   mem_req_valid;
  logic                   mem_req_ready = 1'b0;
  logic [PADDR_WIDTH-1:0] mem_req_addr;
  logic                   mem_resp_valid = 1'b0;
  logic [63:0]            mem_resp_data = '0;

  superh16_itlb_ptw #(.LEVELS(3), .PTE_WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .ptw_req(ptw_req), .ptw_vaddr(ptw_vaddr),
    .ptw_ack(ptw_ack), .ptw_paddr(ptw_paddr), .ptw_page_size(ptw_page_size),
    .ptw_valid(ptw_valid), .ptw_executable(ptw_executable), .satp_ppn(satp_ppn),
    .flush(flush), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned            at;
    logic                   valid;
    logic [PADDR_WIDTH-1:0] paddr;
    logic [1:0]             size;
    logic                   exec;
  } exp_t;

  exp_t                   exp_q[$];
  logic [PADDR_WIDTH-1:0] addr_q[$];
  logic [63:0]            mem [logic [PADDR_WIDTH-1:0]];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Memory model configuration, owned by the stimulus process.
  int unsigned lat_cfg = 1;
  int unsigned stall_cfg = 0;
  int unsigned walk_id = 0;

  // Memory model state, owned by the monitor process.
  int unsigned served_id = 0;
  int unsigned cur_stall = 0;
  int unsigned wait_cnt = 0;
  bit          pend = 0;
  int unsigned resp_at = 0;
  logic [63:0] resp_pte = '0;
  logic [PADDR_WIDTH-1:0] held_addr = '0;

  // Memory responder plus ack scoreboard, all evaluated away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend           = 0;
      wait_cnt       = 0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      addr_q.delete();
    end else begin
      mem_resp_valid = 1'b0;
      if (pend && cyc == resp_at) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = resp_pte;
        pend           = 0;
      end
      mem_req_ready = 1'b0;
      if (mem_req_valid) begin
        if (walk_id != served_id) begin
          served_id = walk_id;
          cur_stall = stall_cfg;
        end
        if (wait_cnt > 0) chk("req_addr_stable", mem_req_addr, held_addr);
        held_addr = mem_req_addr;
        if (wait_cnt >= cur_stall) begin
          mem_req_ready = 1'b1;
          chk("single_outstanding", 64'(pend), 64'd0);
          if (addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: actual addr 0x%0h required none (cycle %0d)", mem_req_addr, cyc);
          end else begin
            chk("req_addr", mem_req_addr, addr_q.pop_front());
          end
          resp_pte  = mem.exists(mem_req_addr) ? mem[mem_req_addr] : 64'h0;
          resp_at   = cyc + lat_cfg;
          pend      = 1;
          wait_cnt  = 0;
          cur_stall = 0;
        end else begin
          wait_cnt++;
        end
      end

      if (ptw_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack: actual ack valid=%0b paddr=0x%0h required none (cycle %0d)", ptw_valid, ptw_paddr, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("ack_cycle", 64'(cyc), 64'(e.at));
          chk("ack_valid", 64'(ptw_valid), 64'(e.valid));
          if (e.valid) begin
            chk("ack_paddr", 64'(ptw_paddr), 64'(e.paddr));
            chk("ack_size", 64'(ptw_page_size), 64'(e.size));
            chk("ack_exec", 64'(ptw_executable), 64'(e.exec));
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Issue at a negedge; 'lat' is the ack cycle relative to the issue cycle.
  task automatic issue(input logic [63:0] va, input int unsigned lat, input logic v,
                       input logic [PADDR_WIDTH-1:0] pa, input logic [1:0] sz, input logic ex);
    exp_t e;
    e.at = cyc + lat; e.valid = v; e.paddr = pa; e.size = sz; e.exec = ex;
    exp_q.push_back(e);
    walk_id++;
    ptw_vaddr = va;
    ptw_req   = 1'b1;
  endtask

  task automatic finish_walk(input int budget, input bit drop);
    int n = 0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (ptw_ack) break;
    end
    chk("walk_done", 64'(ptw_ack), 64'd1);
    if (drop || !ptw_ack) ptw_req = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"},       64'(ptw_ack), 64'd0);
    chk({tag, "_paddr"},     64'(ptw_paddr), 64'd0);
    chk({tag, "_size"},      64'(ptw_page_size), 64'd0);
    chk({tag, "_valid"},     64'(ptw_valid), 64'd0);
    chk({tag, "_exec"},      64'(ptw_executable), 64'd0);
    chk({tag, "_mem_valid"}, 64'(mem_req_valid), 64'd0);
    chk({tag, "_mem_addr"},  64'(mem_req_addr), 64'd0);
  endtask

  initial begin
    // Page tables rooted at PPN 0x100.
    mem[56'h100008] = (64'h101 << 10) | 64'h1;        // L2[1] -> table 0x101
    mem[56'h100010] = (64'h40000 << 10) | 64'h3;      // L2[2] 1GB leaf R, no X
    mem[56'h101000] = (64'h102 << 10) | 64'h1;        // L1[0] -> table 0x102
    mem[56'h101008] = (64'h400 << 10) | 64'hB;        // L1[1] 2MB leaf RX
    mem[56'h101010] = (64'h401 << 10) | 64'hB;        // L1[2] misaligned 2MB
    mem[56'h102008] = (64'h80000 << 10) | 64'h9;      // L0[1] 4KB leaf X

    idle(2);
    chk_all_zero("reset");
    rst_n = 1'b1;
    idle(2);

    // 4KB walk, one-cycle memory.
    addr_q.push_back(56'h100008); addr_q.push_back(56'h101000); addr_q.push_back(56'h102008);
    issue(64'h0000_0000_4000_1ABC, 7, 1'b1, 56'h8000_0000, PAGE_4K, 1'b1);
    finish_walk(60, 1'b1);
    idle(2);

    // 1GB leaf, not executable.
    addr_q.push_back(56'h100010);
    issue(64'h0000_0000_8000_0000, 3, 1'b1, 56'h4000_0000, PAGE_1G, 1'b0);
    finish_walk(60, 1'b1);
    idle(2);

    // 2MB leaf.
    addr_q.push_back(56'h100008); addr_q.push_back(56'h101008);
    issue(64'h0000_0000_4020_0000, 5, 1'b1, 56'h40_0000, PAGE_2M, 1'b1);
    finish_walk(60, 1'b1);
    idle(2);

    // Misaligned 2MB: fault, then held request must not be re-walked.
    addr_q.push_back(56'h100008); addr_q.push_back(56'h101010);
    issue(64'h0000_0000_4040_0000, 5, 1'b0, '0, PAGE_4K, 1'b0);
    finish_walk(60, 1'b0);
    idle(8);
    ptw_req = 1'b0;
    idle(3);

    // Non-canonical: immediate fault, no memory traffic.
    issue(64'h0000_8000_0000_0000, 1, 1'b0, '0, PAGE_4K, 1'b0);
    finish_walk(60, 1'b1);
    idle(3);

    // Canonical upper-half address hitting an invalid root entry.
    addr_q.push_back(56'h100800);
    issue(64'hFFFF_FFC0_0000_0000, 3, 1'b0, '0, PAGE_4K, 1'b0);
    finish_walk(60, 1'b1);
    idle(3);

    // Ready held low 3 cycles, latency 5: 7 + 3 + 4*3.
    lat_cfg = 5; stall_cfg = 3;
    addr_q.push_back(56'h100008); addr_q.push_back(56'h101000); addr_q.push_back(56'h102008);
    issue(64'h0000_0000_4000_1ABC, 22, 1'b1, 56'h8000_0000, PAGE_4K, 1'b1);
    finish_walk(60, 1'b1);
    idle(3);

    // Request dropped while waiting at level 1: drain, no ack.
    stall_cfg = 0;
    addr_q.push_back(56'h100008); addr_q.push_back(56'h101000);
    walk_id++;
    ptw_vaddr = 64'h0000_0000_4000_1ABC;
    ptw_req   = 1'b1;
    idle(9);
    ptw_req = 1'b0;
    idle(8);
    chk("abort_reqs_issued", 64'(addr_q.size()), 64'd0);
    lat_cfg = 1;
    addr_q.push_back(56'h100010);
    issue(64'h0000_0000_8000_0000, 3, 1'b1, 56'h4000_0000, PAGE_1G, 1'b0);
    finish_walk(60, 1'b1);
    idle(2);

    // Asynchronous reset mid-walk.
    lat_cfg = 5;
    addr_q.push_back(56'h100008);
    walk_id++;
    ptw_vaddr = 64'h0000_0000_4000_1ABC;
    ptw_req   = 1'b1;
    idle(4);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    ptw_req = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(2);

    // Clean walk after reset.
    lat_cfg = 1;
    addr_q.push_back(56'h100008); addr_q.push_back(56'h101008);
    issue(64'h0000_0000_4020_0000, 5, 1'b1, 56'h40_0000, PAGE_2M, 1'b1);
    finish_walk(60, 1'b1);
    idle(4);

    chk("acks_outstanding", 64'(exp_q.size()), 64'd0);
    chk("reqs_outstanding", 64'(addr_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
